riscv_aes_result_writeback: RTL and testbench

- Return path of the AES accelerator. Takes the 128-bit AES result and writes it back into the core's general-purpose register file as four 32-bit words.
- The words go to consecutive destination registers through the shared register-file write port.
- It is the drain side of the AES register file: that file collects data and key words from the core; this block hands results back to the core.
- It stalls the pipeline while the writeback is in progress.

---
 rtl/riscv_aes_pkg.sv | 15 +
 rtl/riscv_aes_result_writeback.sv | 148 ++++++++++++++
 tb/tb_riscv_aes_result_writeback.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_aes_pkg.sv
// rtl/riscv_aes_pkg.sv - shared types and constants for the AES result writeback path
// Purpose: state encoding and sizing constants used by riscv_aes_result_writeback.
package riscv_aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } aes_wb_state_e;

  localparam int AES_BLOCK_WIDTH = 128;
  localparam int AES_NUM_WORDS   = 4;
  localparam int RF_ZERO_ADDR    = 0;

endpackage

// File: rtl/riscv_aes_result_writeback.sv
// rtl/riscv_aes_result_writeback.sv - writes a 128-bit AES result into the GPR file word by word
// Purpose: captures a completed AES result and drains it as NUM_WORDS consecutive
//          register-file writes through the shared write port, stalling the core meanwhile.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   result_valid_i/_i    AES result handshake and data (word k = bits [32k+31:32k])
//   result_ready_o       high only in IDLE
//   dest_base_addr_i     destination register of word 0, sampled on accept
//   flush_i              aborts an in-progress writeback; blocks accept in IDLE
//   wb_waddr_o/wdata_o   register-file write address / data
//   wb_we_o, wb_gnt_i    write request and arbiter grant
//   busy_o, done_o       core stall, one-cycle completion pulse
module riscv_aes_result_writeback
  import riscv_aes_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int NUM_WORDS     = AES_NUM_WORDS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            result_valid_i,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] result_i,
  output logic                            result_ready_o,
  input  logic [RF_ADDR_WIDTH-1:0]        dest_base_addr_i,
  input  logic                            flush_i,
  output logic [RF_ADDR_WIDTH-1:0]        wb_waddr_o,
  output logic [DATA_WIDTH-1:0]           wb_wdata_o,
  output logic                            wb_we_o,
  input  logic                            wb_gnt_i,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int RES_W = NUM_WORDS * DATA_WIDTH;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0]         LAST_CNT  = CNT_W'(NUM_WORDS - 1);
  localparam logic [RF_ADDR_WIDTH-1:0] ZERO_ADDR = RF_ADDR_WIDTH'(RF_ZERO_ADDR);

  aes_wb_state_e              state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [RF_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [RES_W-1:0]           result_q, result_d;
  logic                       wb_we_q, wb_we_d;
  logic [RF_ADDR_WIDTH-1:0]   wb_waddr_q, wb_waddr_d;
  logic [DATA_WIDTH-1:0]      wb_wdata_q, wb_wdata_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       ready_q, ready_d;

  logic [RF_ADDR_WIDTH-1:0]   cur_addr;
  logic [RF_ADDR_WIDTH-1:0]   next_addr;
  logic                       advance;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    result_d = result_q;

    // Register x0 is never written: that word retires without a grant.
    cur_addr = base_q + RF_ADDR_WIDTH'(cnt_q);
    advance  = wb_gnt_i || (cur_addr == ZERO_ADDR);

    unique case (state_q)
      IDLE: begin
        // Flush outranks accept so a result arriving with a flush is left with the AES core.
        if (!flush_i && result_valid_i) begin
          result_d = result_i;
          base_d   = dest_base_addr_i;
          cnt_d    = '0;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (advance) begin
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from next-state values so they come straight off flops.
    next_addr  = base_d + RF_ADDR_WIDTH'(cnt_d);
    wb_we_d    = (state_d == WRITE) && (next_addr != ZERO_ADDR);
    wb_waddr_d = (state_d == WRITE) ? next_addr : '0;
    wb_wdata_d = '0;
    if (state_d == WRITE) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (int'(cnt_d) == k) begin
          wb_wdata_d = result_d[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      result_q   <= '0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      result_q   <= result_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign wb_we_o        = wb_we_q;
  assign wb_waddr_o     = wb_waddr_q;
  assign wb_wdata_o     = wb_wdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign result_ready_o = ready_q;

endmodule

// File: tb/tb_riscv_aes_result_writeback.sv
// tb/tb_riscv_aes_result_writeback.sv - self-checking bench for riscv_aes_result_writeback
module tb_riscv_aes_result_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         result_valid_i;
  logic [127:0] result_i;
  logic         result_ready_o;
  logic [4:0]   dest_base_addr_i;
  logic         flush_i;
  logic [4:0]   wb_waddr_o;
  logic [31:0]  wb_wdata_o;
  logic         wb_we_o;
  logic         wb_gnt_i;
  logic         busy_o;
  logic         done_o;

  int n_cmp = 0;
  int n_err = 0;

  riscv_aes_result_writeback #(
    .DATA_WIDTH(32), .RF_ADDR_WIDTH(5), .NUM_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .result_valid_i(result_valid_i), .result_i(result_i), .result_ready_o(result_ready_o),
    .dest_base_addr_i(dest_base_addr_i), .flush_i(flush_i),
    .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o), .wb_we_o(wb_we_o),
    .wb_gnt_i(wb_gnt_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] res;
    logic [4:0]   base;
    int           stall_idx;   // index into the expected write list that sees no grant
    int           stall_n;     // number of refused cycles on that write
    int           exp_writes;
    int           exp_busy;
  } vec_t;

  vec_t tbl[6];

  localparam logic [127:0] RES_A = 128'hcafeface_deafbabe_deadbeef_01234567;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents a result in an IDLE cycle; returns one cycle later (first WRITE cycle).
  task automatic accept(input logic [127:0] res, input logic [4:0] base);
    check("ready_before_accept", result_ready_o, 1);
    result_valid_i   = 1'b1;
    result_i         = res;
    dest_base_addr_i = base;
    step();
    result_valid_i   = 1'b0;
    result_i         = rnd128();
    dest_base_addr_i = 5'($urandom);
  endtask

  // Reference: each word k lands at (base+k) mod 32, except register 0 which is skipped.
  // exp_writes / exp_busy < 0 mean "take it from the model".
  task automatic drain(input logic [127:0] res, input logic [4:0] base, input int stall_idx,
                       input int stall_n, input bit rnd_gnt, input int exp_writes_in,
                       input int exp_busy_in);
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    int stalls = 0, busy_cnt = 0, dones = 0, wr = 0, left = stall_n, exp_w;
    bit g;
    bit finished = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [4:0] a;
      a = 5'((int'(base) + k) % 32);
      if (a != 5'd0) begin
        qa.push_back(a);
        qd.push_back(res[32*k +: 32]);
      end
    end
    exp_w = (exp_writes_in >= 0) ? exp_writes_in : qa.size();
    check("busy_first_cycle", busy_o, 1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!busy_o) begin
        finished = 1'b1;
        break;
      end
      busy_cnt++;
      if (result_ready_o !== 1'b0) check("ready_low_while_busy", result_ready_o, 0);
      if (done_o) begin
        dones++;
        check("done_after_all_writes", qa.size(), 0);
      end
      g = 1'b1;
      if (rnd_gnt) g = 1'($urandom_range(0, 1));
      else if (wb_we_o && wr == stall_idx && left > 0) begin
        g = 1'b0;
        left--;
      end
      wb_gnt_i = g;
      if (wb_we_o) begin
        if (qa.size() == 0) begin
          check("unexpected_write_addr", wb_waddr_o, 5'h1f);
        end else begin
          check("wr_addr", wb_waddr_o, qa[0]);
          check("wr_data", wb_wdata_o, qd[0]);
          if (g) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
            wr++;
          end else begin
            stalls++;
          end
        end
      end
      step();
    end
    wb_gnt_i = 1'b1;
    check("drain_finished_in_budget", finished, 1);
    check("ready_after_busy", result_ready_o, 1);
    check("done_pulses", dones, 1);
    check("num_writes", wr, exp_w);
    check("busy_cycles", busy_cnt, (exp_busy_in >= 0) ? exp_busy_in : 4 + stalls + 1);
  endtask

  initial begin
    rst              = 1'b1;
    result_valid_i   = 1'b0;
    result_i         = '0;
    dest_base_addr_i = '0;
    flush_i          = 1'b0;
    wb_gnt_i         = 1'b1;

    tbl[0] = '{RES_A, 5'd5,  -1, 0, 4, 5};
    tbl[1] = '{RES_A, 5'd5,   1, 2, 4, 7};
    tbl[2] = '{RES_A, 5'd30, -1, 0, 3, 5};
    tbl[3] = '{128'h44444444_33333333_22222222_11111111, 5'd0, 0, 1, 3, 6};
    tbl[4] = '{128'h0badf00d_600dcafe_12345678_9abcdef0, 5'd29, 2, 3, 3, 8};
    tbl[5] = '{128'hffffffff_00000000_a5a5a5a5_5a5a5a5a, 5'd31, -1, 0, 3, 5};

    // Reset state
    #12;
    check("rst_we",    wb_we_o, 0);
    check("rst_addr",  wb_waddr_o, 0);
    check("rst_data",  wb_wdata_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_done",  done_o, 0);
    check("rst_ready", result_ready_o, 1);
    rst = 1'b0;
    step();

    // Directed table
    foreach (tbl[i]) begin
      accept(tbl[i].res, tbl[i].base);
      drain(tbl[i].res, tbl[i].base, tbl[i].stall_idx, tbl[i].stall_n, 1'b0,
            tbl[i].exp_writes, tbl[i].exp_busy);
      step();
    end

    // Back-pressure: second result held valid during the first writeback
    begin
      logic [127:0] res_b;
      res_b = 128'h0f0f0f0f_f0f0f0f0_13579bdf_2468ace0;
      accept(RES_A, 5'd5);
      result_valid_i   = 1'b1;
      result_i         = res_b;
      dest_base_addr_i = 5'd10;
      drain(RES_A, 5'd5, -1, 0, 1'b0, 4, 5);
      step();
      result_valid_i   = 1'b0;
      result_i         = rnd128();
      dest_base_addr_i = 5'd3;
      drain(res_b, 5'd10, -1, 0, 1'b0, 4, 5);
      step();
    end

    // Flush after word 1 is granted
    accept(RES_A, 5'd5);
    step();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_we_low",   wb_we_o, 0);
    check("flush_busy_low", busy_o, 0);
    check("flush_no_done",  done_o, 0);
    check("flush_ready",    result_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_quiet_done", done_o, 0);
      check("flush_quiet_we",   wb_we_o, 0);
    end
    accept(128'h11112222_33334444_55556666_77778888, 5'd12);
    drain(128'h11112222_33334444_55556666_77778888, 5'd12, -1, 0, 1'b0, 4, 5);
    step();

    // Flush in IDLE wins over a valid result
    flush_i          = 1'b1;
    result_valid_i   = 1'b1;
    result_i         = rnd128();
    dest_base_addr_i = 5'd7;
    step();
    flush_i        = 1'b0;
    result_valid_i = 1'b0;
    check("idle_flush_no_busy",  busy_o, 0);
    check("idle_flush_no_we",    wb_we_o, 0);
    check("idle_flush_ready",    result_ready_o, 1);
    step();

    // Randomized transactions against the reference model
    for (int t = 0; t < 30; t++) begin
      logic [127:0] r;
      logic [4:0]   b;
      r = rnd128();
      b = 5'($urandom);
      accept(r, b);
      drain(r, b, -1, 0, 1'b1, -1, -1);
      step();
    end

    // Asynchronous reset in the middle of a writeback
    accept(RES_A, 5'd5);
    check("pre_reset_we", wb_we_o, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_we",    wb_we_o, 0);
    check("arst_addr",  wb_waddr_o, 0);
    check("arst_data",  wb_wdata_o, 0);
    check("arst_busy",  busy_o, 0);
    check("arst_done",  done_o, 0);
    check("arst_ready", result_ready_o, 1);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset_no_write", wb_we_o, 0);
      check("post_reset_idle", busy_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
